// File: rtl/tnn_frame_sequencer_if.sv
// Feature-stream and result handshake bundle for tnn_frame_sequencer.
// The slave modport is the sequencer's view; master is the stream source / result sink.
interface tnn_frame_sequencer_if #(
  parameter int unsigned FEAT_W = 2
) ();
  logic [FEAT_W-1:0] s_feat;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic              m_class;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output s_feat,
    output s_last,
    output s_valid,
    input  s_ready,
    input  m_class,
    input  m_valid,
    output m_ready
  );

  modport slave (
    input  s_feat,
    input  s_last,
    input  s_valid,
    output s_ready,
    output m_class,
    output m_valid,
    input  m_ready
  );
endinterface

// File: rtl/tnn_frame_sequencer.sv
// Collects one sample of NUM_FEAT features, holds them on a combinational classifier core
// for SETTLE_CYCLES, then returns the class bit. Define TNN_SEQ_STATS_EN to build counters.
module tnn_frame_sequencer #(
  parameter int unsigned FEAT_W        = 2,
  parameter int unsigned NUM_FEAT      = 5,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  tnn_frame_sequencer_if.slave         bus,
  output logic [NUM_FEAT*FEAT_W-1:0]   cls_feat,
  input  logic                         cls_out,
  output logic                         frame_err,
  input  logic                         stat_clr,
  output logic [CNT_W-1:0]             stat_frames,
  output logic [CNT_W-1:0]             stat_pos,
  output logic [CNT_W-1:0]             stat_err
);

  localparam int unsigned IdxW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int unsigned SetW = 4;
  localparam int unsigned FW   = NUM_FEAT * FEAT_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_FEAT - 1);

  typedef enum logic [1:0] {
    StCollect,
    StDiscard,
    StSettle,
    StOutput
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [SetW-1:0] cnt_q, cnt_d;
  logic [FW-1:0]   feat_q, feat_d;
  logic            m_valid_q, m_valid_d;
  logic            m_class_q, m_class_d;
  logic            frame_err_q, frame_err_d;

  assign bus.s_ready = (state_q == StCollect) || (state_q == StDiscard);
  assign bus.m_valid = m_valid_q;
  assign bus.m_class = m_class_q;
  assign cls_feat    = feat_q;
  assign frame_err   = frame_err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    feat_d      = feat_q;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (bus.s_valid) begin
          for (int unsigned k = 0; k < NUM_FEAT; k++) begin
            if (idx_q == IdxW'(k)) feat_d[k*FEAT_W +: FEAT_W] = bus.s_feat;
          end
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (bus.s_last) begin
              cnt_d   = SetW'(SETTLE_CYCLES - 1);
              state_d = StSettle;
            end else begin
              // Sample too long: the slots keep beats 0..NUM_FEAT-1, the rest is dropped.
              frame_err_d = 1'b1;
              state_d     = StDiscard;
            end
          end else if (bus.s_last) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StDiscard: begin
        if (bus.s_valid && bus.s_last) state_d = StCollect;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          m_class_d = cls_out;
          m_valid_d = 1'b1;
          state_d   = StOutput;
        end else begin
          cnt_d = cnt_q - SetW'(1);
        end
      end
      StOutput: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      idx_q       <= '0;
      cnt_q       <= '0;
      feat_q      <= '0;
      m_valid_q   <= 1'b0;
      m_class_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      feat_q      <= feat_d;
      m_valid_q   <= m_valid_d;
      m_class_q   <= m_class_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef TNN_SEQ_STATS_EN
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             res_hs;

  assign res_hs = m_valid_q && bus.m_ready;

  always_comb begin
    frames_d = frames_q;
    pos_d    = pos_q;
    err_d    = err_q;
    if (stat_clr) begin
      frames_d = '0;
      pos_d    = '0;
      err_d    = '0;
    end else begin
      if (res_hs && (frames_q != '1)) frames_d = frames_q + CNT_W'(1);
      if (res_hs && m_class_q && (pos_q != '1)) pos_d = pos_q + CNT_W'(1);
      // Counted as the pulse is launched so it lands on the same edge as frame_err.
      if (frame_err_d && (err_q != '1)) err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      pos_q    <= '0;
      err_q    <= '0;
    end else begin
      frames_q <= frames_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

  assign stat_frames = frames_q;
  assign stat_pos    = pos_q;
  assign stat_err    = err_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_frames     = '0;
  assign stat_pos        = '0;
  assign stat_err        = '0;
`endif

endmodule

// File: tb/tb_tnn_frame_sequencer.sv
// Directed bench for tnn_frame_sequencer: a table of full samples plus hand-written
// sequences for malformed samples, stalls, stat clear and mid-sample reset.
module tb_tnn_frame_sequencer;

`ifdef TNN_SEQ_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic clk;
  logic rst_n;

  tnn_frame_sequencer_if #(.FEAT_W(2)) bus0 ();
  tnn_frame_sequencer_if #(.FEAT_W(2)) bus1 ();

  logic [9:0]  cls_feat0, cls_feat1;
  logic        cls_out0, cls_out1;
  logic        frame_err0, frame_err1;
  logic        stat_clr0, stat_clr1;
  logic [15:0] frames0, pos0, errc0, frames1, pos1, errc1;

  // Core stub: odd parity of the feature vector.
  assign cls_out0 = ^cls_feat0;
  assign cls_out1 = ^cls_feat1;

  tnn_frame_sequencer #(.FEAT_W(2), .NUM_FEAT(5), .SETTLE_CYCLES(1), .CNT_W(16)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus0),
    .cls_feat   (cls_feat0),
    .cls_out    (cls_out0),
    .frame_err  (frame_err0),
    .stat_clr   (stat_clr0),
    .stat_frames(frames0),
    .stat_pos   (pos0),
    .stat_err   (errc0)
  );

  tnn_frame_sequencer #(.FEAT_W(2), .NUM_FEAT(5), .SETTLE_CYCLES(3), .CNT_W(16)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus1),
    .cls_feat   (cls_feat1),
    .cls_out    (cls_out1),
    .frame_err  (frame_err1),
    .stat_clr   (stat_clr1),
    .stat_frames(frames1),
    .stat_pos   (pos1),
    .stat_err   (errc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_pulses;
  int err_beat;

  typedef struct {
    logic [1:0] f [5];
    logic [9:0] exp_feat;
    logic       exp_cls;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // s_ready and m_valid must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (bus0.s_ready && bus0.m_valid) begin
        errors++;
        $display("FAIL ready_valid_excl0: got s_ready=1 m_valid=1, want not both");
      end
    end
  end

  task automatic send0(input logic [1:0] beats [8], input int n);
    err_pulses = 0;
    err_beat   = 0;
    for (int i = 0; i < n; i++) begin
      bus0.s_valid = 1'b1;
      bus0.s_feat  = beats[i];
      bus0.s_last  = (i == n - 1);
      tick();
      if (frame_err0) begin
        err_pulses++;
        err_beat = i + 1;
      end
    end
    bus0.s_valid = 1'b0;
    bus0.s_last  = 1'b0;
  endtask

  task automatic wait_result0(output int lat);
    lat = 0;
    while (!bus0.m_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake0();
    bus0.m_ready = 1'b1;
    tick();
    bus0.m_ready = 1'b0;
  endtask

  task automatic run_sample0(input string name, input logic [1:0] b0, input logic [1:0] b1,
                             input logic [1:0] b2, input logic [1:0] b3, input logic [1:0] b4,
                             input logic [9:0] exp_feat, input logic exp_cls);
    logic [1:0] bb [8];
    int lat;
    bb = '{b0, b1, b2, b3, b4, 2'd0, 2'd0, 2'd0};
    send0(bb, 5);
    wait_result0(lat);
    check({name, "_latency"}, lat, 1);
    check({name, "_feat"}, cls_feat0, exp_feat);
    check({name, "_class"}, bus0.m_class, exp_cls);
    handshake0();
    check({name, "_mvalid_drop"}, bus0.m_valid, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] bb [8];
    int lat;
    int seen;

    vecs[0].f = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2}; vecs[0].exp_feat = 10'b10_00_11_10_01;
    vecs[0].exp_cls = 1'b1;
    vecs[1].f = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0}; vecs[1].exp_feat = 10'b00_00_00_00_00;
    vecs[1].exp_cls = 1'b0;
    vecs[2].f = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3}; vecs[2].exp_feat = 10'b11_11_11_11_11;
    vecs[2].exp_cls = 1'b0;
    vecs[3].f = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0}; vecs[3].exp_feat = 10'b00_00_00_00_01;
    vecs[3].exp_cls = 1'b1;
    vecs[4].f = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd1}; vecs[4].exp_feat = 10'b01_11_00_01_10;
    vecs[4].exp_cls = 1'b1;

    rst_n = 1'b0;
    bus0.s_valid = 0; bus0.s_last = 0; bus0.s_feat = 0; bus0.m_ready = 0;
    bus1.s_valid = 0; bus1.s_last = 0; bus1.s_feat = 0; bus1.m_ready = 0;
    stat_clr0 = 0; stat_clr1 = 0;
    #1;
    check("rst_s_ready", bus0.s_ready, 1);
    check("rst_m_valid", bus0.m_valid, 0);
    check("rst_m_class", bus0.m_class, 0);
    check("rst_cls_feat", cls_feat0, 0);
    check("rst_frame_err", frame_err0, 0);
    check("rst_stats", {frames0, pos0} | {16'd0, errc0}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      bb = '{vecs[i].f[0], vecs[i].f[1], vecs[i].f[2], vecs[i].f[3], vecs[i].f[4],
             2'd0, 2'd0, 2'd0};
      send0(bb, 5);
      check($sformatf("vec%0d_no_err", i), err_pulses, 0);
      wait_result0(lat);
      check($sformatf("vec%0d_latency", i), lat, 1);
      check($sformatf("vec%0d_feat", i), cls_feat0, vecs[i].exp_feat);
      check($sformatf("vec%0d_class", i), bus0.m_class, vecs[i].exp_cls);
      check($sformatf("vec%0d_s_ready_out", i), bus0.s_ready, 0);
      handshake0();
      check($sformatf("vec%0d_mvalid_drop", i), bus0.m_valid, 0);
      check($sformatf("vec%0d_s_ready_back", i), bus0.s_ready, 1);
      if (i == 0) begin
        check("vec0_frames", frames0, StatsOn ? 1 : 0);
        check("vec0_pos", pos0, StatsOn ? 1 : 0);
      end
    end
    check("table_frames", frames0, StatsOn ? 5 : 0);
    check("table_pos", pos0, StatsOn ? 3 : 0);

    // Short sample: three beats of 1 overwrite slots 0..2 only.
    bb = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    send0(bb, 3);
    check("short_err_pulses", err_pulses, 1);
    check("short_err_beat", err_beat, 3);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus0.m_valid) seen++;
    end
    check("short_no_mvalid", seen, 0);
    check("short_feat", cls_feat0, 10'b01_11_01_01_01);
    check("short_s_ready", bus0.s_ready, 1);
    run_sample0("after_short", 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 10'b00_11_10_01_00, 1'b0);
    check("short_stat_err", errc0, StatsOn ? 1 : 0);

    // Long sample: error on beat 5, beats 6-7 dropped.
    bb = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0};
    send0(bb, 7);
    check("long_err_pulses", err_pulses, 1);
    check("long_err_beat", err_beat, 5);
    check("long_feat", cls_feat0, 10'b10_10_10_10_10);
    check("long_no_mvalid", bus0.m_valid, 0);
    check("long_s_ready", bus0.s_ready, 1);
    run_sample0("after_long", 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 10'b00_00_00_00_11, 1'b0);
    check("long_stat_err", errc0, StatsOn ? 2 : 0);
    check("pre_clr_frames", frames0, StatsOn ? 7 : 0);
    check("pre_clr_pos", pos0, StatsOn ? 3 : 0);

    // Stat clear coinciding with a class-1 result handshake.
    bb = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    send0(bb, 5);
    wait_result0(lat);
    check("clr_latency", lat, 1);
    check("clr_class", bus0.m_class, 1);
    stat_clr0    = 1'b1;
    bus0.m_ready = 1'b1;
    tick();
    stat_clr0    = 1'b0;
    bus0.m_ready = 1'b0;
    check("clr_frames", frames0, 0);
    check("clr_pos", pos0, 0);
    check("clr_err", errc0, 0);

    // Reset while in SETTLE.
    bb = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    send0(bb, 5);
    check("settle_feat", cls_feat0, 10'b01_01_01_01_01);
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", bus0.m_valid, 0);
    check("midrst_cls_feat", cls_feat0, 0);
    check("midrst_s_ready", bus0.s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus0.m_valid) seen++;
    end
    check("midrst_no_result", seen, 0);
    run_sample0("after_rst", 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 10'b10_00_11_10_01, 1'b1);

    // SETTLE_CYCLES=3 instance with a 4-cycle result stall.
    bb = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      bus1.s_valid = 1'b1;
      bus1.s_feat  = bb[i];
      bus1.s_last  = (i == 4);
      tick();
    end
    bus1.s_valid = 1'b0;
    bus1.s_last  = 1'b0;
    lat  = 0;
    seen = 0;
    while (!bus1.m_valid && lat < 40) begin
      if (bus1.s_ready) seen++;
      tick();
      lat++;
    end
    check("s3_latency", lat, 3);
    check("s3_settle_s_ready", seen, 0);
    check("s3_feat", cls_feat1, 10'b10_00_11_10_01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("s3_stall%0d_valid", i), bus1.m_valid, 1);
      check($sformatf("s3_stall%0d_class", i), bus1.m_class, 1);
      check($sformatf("s3_stall%0d_s_ready", i), bus1.s_ready, 0);
    end
    bus1.m_ready = 1'b1;
    tick();
    bus1.m_ready = 1'b0;
    check("s3_mvalid_drop", bus1.m_valid, 0);
    check("s3_s_ready_back", bus1.s_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
